// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler
//   Register-file writeback arbiter and issue scoreboard.
//   - One RF write port is shared by the pipeline WB (absolute priority) and
//     the multiply/divide unit WB (granted only when the pipeline is idle).
//   - Each register 1..31 keeps a 2-bit pending-write counter. Issue is held
//     off on a RAW hazard (unless covered by the same-cycle write bypass), on
//     counter saturation, or when the MDU WB has been starved too long.
// Ports
//   clk, rst_n                      clock, async active-low reset
//   issue_*_i / stall_o             decode-stage issue request and hold-off
//   pipe_wb_*_i                     pipeline WB request (never back-pressured)
//   mdu_wb_*_i / mdu_wb_ready_o     MDU WB request and grant
//   rf_we_o, rf_wa_o, rf_wd_o       register-file write port
//   flush_i                         clears all pending counters
//   busy_o                          per-register pending flag (registered)
module rf_wb_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_ra1_i,
  input  logic [4:0]  issue_ra2_i,
  input  logic        issue_use1_i,
  input  logic        issue_use2_i,
  input  logic        issue_wr_i,
  input  logic [4:0]  issue_wa_i,
  output logic        stall_o,
  input  logic        pipe_wb_valid_i,
  input  logic [4:0]  pipe_wb_wa_i,
  input  logic [31:0] pipe_wb_wd_i,
  input  logic        mdu_wb_valid_i,
  input  logic [4:0]  mdu_wb_wa_i,
  input  logic [31:0] mdu_wb_wd_i,
  output logic        mdu_wb_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_wa_o,
  output logic [31:0] rf_wd_o,
  input  logic        flush_i,
  output logic [31:0] busy_o
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  r_cnt [32];
  logic [3:0]  r_starve;

  logic [1:0]  w_cnt_nxt [32];
  logic [3:0]  w_starve_nxt;
  logic        w_mdu_grant;
  logic        w_src1_busy;
  logic        w_src2_busy;
  logic        w_dst_full;
  logic        w_starved;
  logic        w_accept;
  logic [31:0] w_inc_vec;
  logic [31:0] w_dec_vec;

  // Write-port arbitration
  assign w_mdu_grant    = mdu_wb_valid_i & ~pipe_wb_valid_i;
  assign mdu_wb_ready_o = w_mdu_grant;

  always_comb begin
    rf_we_o = 1'b0;
    rf_wa_o = '0;
    rf_wd_o = '0;
    if (pipe_wb_valid_i) begin
      rf_we_o = 1'b1;
      rf_wa_o = pipe_wb_wa_i;
      rf_wd_o = pipe_wb_wd_i;
    end else if (w_mdu_grant) begin
      rf_we_o = 1'b1;
      rf_wa_o = mdu_wb_wa_i;
      rf_wd_o = mdu_wb_wd_i;
    end
  end

  // A source with exactly one pending write that is being committed this
  // cycle is satisfied by the RF read-after-write bypass.
  function automatic logic src_busy(input logic en, input logic [4:0] a);
    logic pend;
    logic bypass;
    pend   = en && (a != 5'd0) && (r_cnt[a] != 2'd0);
    bypass = rf_we_o && (rf_wa_o == a) && (r_cnt[a] == 2'd1);
    return pend && !bypass;
  endfunction

  assign w_src1_busy = src_busy(issue_use1_i, issue_ra1_i);
  assign w_src2_busy = src_busy(issue_use2_i, issue_ra2_i);
  assign w_dst_full  = issue_wr_i && (issue_wa_i != 5'd0) && (r_cnt[issue_wa_i] == 2'd3);
  assign w_starved   = (r_starve >= LP_LIMIT);

  assign stall_o  = issue_valid_i & (w_src1_busy | w_src2_busy | w_dst_full | w_starved);
  assign w_accept = issue_valid_i & ~stall_o;

  assign w_inc_vec = (w_accept && issue_wr_i) ? (32'd1 << issue_wa_i) : 32'd0;
  assign w_dec_vec = rf_we_o ? (32'd1 << rf_wa_o) : 32'd0;

  // Register 0 never holds a count; flush wins over any inc/dec.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (r == 0 || flush_i) begin
        w_cnt_nxt[r] = 2'd0;
      end else if (w_inc_vec[r] && !w_dec_vec[r]) begin
        w_cnt_nxt[r] = r_cnt[r] + 2'd1;
      end else if (w_dec_vec[r] && !w_inc_vec[r] && (r_cnt[r] != 2'd0)) begin
        w_cnt_nxt[r] = r_cnt[r] - 2'd1;
      end
    end
  end

  always_comb begin
    w_starve_nxt = 4'd0;
    if (mdu_wb_valid_i && !w_mdu_grant) begin
      w_starve_nxt = (r_starve == 4'd15) ? 4'd15 : r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        r_cnt[r] <= 2'd0;
      end
      r_starve <= 4'd0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int r = 1; r < 32; r++) begin
      busy_o[r] = (r_cnt[r] != 2'd0);
    end
  end

endmodule
